// File: rtl/conv_mul_mac_pipe_if.sv
// ---------------------------------------------------------------------------
// conv_mul_mac_pipe_if
// Streaming bus between a tap producer (line-buffer / weight fetch or an HLS
// control FSM) and the conv_mul_mac_pipe multiply-accumulate core.
//
// Signals:
//   ce        clock enable; 0 freezes the whole core
//   in_valid  din0/din1/acc_en/acc_clr carry a tap this cycle
//   acc_en    1 = add product to running sum, 0 = load product
//   acc_clr   with acc_en = 1, start a new window (previous sum taken as 0)
//   din0      signed pixel/activation operand
//   din1      signed weight operand
//   out_valid dout holds a freshly produced result
//   dout      accumulator contents, two's complement
//   sat_flag  (CONV_MUL_MAC_SAT_EN builds only) result was clamped
//
// Modports: master = tap producer, slave = multiply-accumulate core.
// Optional feature macro: CONV_MUL_MAC_SAT_EN adds sat_flag.
// ---------------------------------------------------------------------------
interface conv_mul_mac_pipe_if #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 32
);
  logic                         ce;
  logic                         in_valid;
  logic                         acc_en;
  logic                         acc_clr;
  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic                         out_valid;
  logic signed [dout_WIDTH-1:0] dout;
`ifdef CONV_MUL_MAC_SAT_EN
  logic                         sat_flag;

  modport master (
    output ce, in_valid, acc_en, acc_clr, din0, din1,
    input  out_valid, dout, sat_flag
  );

  modport slave (
    input  ce, in_valid, acc_en, acc_clr, din0, din1,
    output out_valid, dout, sat_flag
  );
`else
  modport master (
    output ce, in_valid, acc_en, acc_clr, din0, din1,
    input  out_valid, dout
  );

  modport slave (
    input  ce, in_valid, acc_en, acc_clr, din0, din1,
    output out_valid, dout
  );
`endif
endinterface

// File: rtl/conv_mul_mac_pipe.sv
// ---------------------------------------------------------------------------
// conv_mul_mac_pipe
// Pipelined signed multiplier with an optional running-sum accumulator, used
// to build convolution dot products one tap per enabled cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears every register, wins over ce
//   bus    conv_mul_mac_pipe_if.slave (ce, in_valid, acc_en, acc_clr,
//          din0, din1 in; out_valid, dout [, sat_flag] out)
//
// Parameters:
//   ID          instance tag, no functional effect
//   NUM_STAGE   latency in enabled edges from accept to out_valid (1..6)
//   din0_WIDTH  width of signed din0
//   din1_WIDTH  width of signed din1
//   dout_WIDTH  accumulator width (8..48)
//
// Optional feature macro: CONV_MUL_MAC_SAT_EN
//   undefined: product truncation and accumulation wrap modulo 2^dout_WIDTH
//   defined:   both saturate to the dout_WIDTH signed range, sat_flag marks
//              clamped results
//
// Stage layout (NUM_STAGE >= 2): stage 1 registers operands and control,
// stages 2..NUM_STAGE-1 carry the fitted product with its control, the last
// stage updates the accumulator. NUM_STAGE = 1 feeds the multiplier straight
// into the accumulator register.
// ---------------------------------------------------------------------------
module conv_mul_mac_pipe #(
  parameter logic [31:0] ID         = 32'd1,
  parameter int          NUM_STAGE  = 3,
  parameter int          din0_WIDTH = 16,
  parameter int          din1_WIDTH = 8,
  parameter int          dout_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  conv_mul_mac_pipe_if.slave bus
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int DW = dout_WIDTH;
  localparam int EW = (PW > DW) ? PW : DW;

`ifdef CONV_MUL_MAC_SAT_EN
  // Carried product word is {clamped, value}.
  localparam int CW = DW + 1;
  localparam int XW = EW + 1;
  localparam logic signed [XW-1:0] MAX_X = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_X = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX_D = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_D = {1'b1, {(DW-1){1'b0}}};
`else
  localparam int CW = DW;
`endif

  // Full-precision signed product; operands are widened first so no
  // partial product is lost.
  function automatic logic signed [PW-1:0] mul_full(
    input logic signed [din0_WIDTH-1:0] a,
    input logic signed [din1_WIDTH-1:0] b
  );
    mul_full = PW'(a) * PW'(b);
  endfunction

`ifdef CONV_MUL_MAC_SAT_EN
  // Fit the product into DW bits, clamping when it does not fit.
  function automatic logic [CW-1:0] fit_prod(input logic signed [PW-1:0] p);
    logic signed [XW-1:0] ext;
    ext = XW'(p);
    if (ext > MAX_X)
      fit_prod = {1'b1, MAX_D};
    else if (ext < MIN_X)
      fit_prod = {1'b1, MIN_D};
    else
      fit_prod = {1'b0, ext[DW-1:0]};
  endfunction

  // Saturating add; the extra sum bit disagreeing with the sign bit means
  // the true sum left the DW-bit range.
  function automatic logic [DW:0] add_acc(
    input logic signed [DW-1:0] acc,
    input logic signed [DW-1:0] p
  );
    logic signed [DW:0] s;
    s = {acc[DW-1], acc} + {p[DW-1], p};
    if (s[DW] != s[DW-1])
      add_acc = s[DW] ? {1'b1, MIN_D} : {1'b1, MAX_D};
    else
      add_acc = {1'b0, s[DW-1:0]};
  endfunction
`else
  // Sign-extend or keep the low DW bits of the product.
  function automatic logic [CW-1:0] fit_prod(input logic signed [PW-1:0] p);
    logic signed [EW-1:0] ext;
    ext = EW'(p);
    fit_prod = ext[DW-1:0];
  endfunction

  // Modular add.
  function automatic logic signed [DW-1:0] add_acc(
    input logic signed [DW-1:0] acc,
    input logic signed [DW-1:0] p
  );
    add_acc = acc + p;
  endfunction
`endif

  // Inputs to the accumulator stage, whatever the pipeline depth.
  logic          fin_vld;
  logic          fin_en;
  logic          fin_clr;
  logic [CW-1:0] fin_word;

  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign fin_vld  = bus.in_valid;
      assign fin_en   = bus.acc_en;
      assign fin_clr  = bus.acc_clr;
      assign fin_word = fit_prod(mul_full(bus.din0, bus.din1));
    end else begin : g_pipe
      logic                         vld_p1;
      logic                         en_p1;
      logic                         clr_p1;
      logic signed [din0_WIDTH-1:0] a_p1;
      logic signed [din1_WIDTH-1:0] b_p1;
      logic [CW-1:0]                word_p1;

      // ---- stage 1: operand and control capture ----
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1 <= 1'b0;
          en_p1  <= 1'b0;
          clr_p1 <= 1'b0;
          a_p1   <= '0;
          b_p1   <= '0;
        end else if (bus.ce) begin
          vld_p1 <= bus.in_valid;
          en_p1  <= bus.acc_en;
          clr_p1 <= bus.acc_clr;
          a_p1   <= bus.din0;
          b_p1   <= bus.din1;
        end
      end

      assign word_p1 = fit_prod(mul_full(a_p1, b_p1));

      if (NUM_STAGE == 2) begin : g_direct
        assign fin_vld  = vld_p1;
        assign fin_en   = en_p1;
        assign fin_clr  = clr_p1;
        assign fin_word = word_p1;
      end else begin : g_carry
        localparam int LAST = NUM_STAGE - 1;

        logic          vld_pn  [2:LAST];
        logic          en_pn   [2:LAST];
        logic          clr_pn  [2:LAST];
        logic [CW-1:0] word_pn [2:LAST];

        // ---- stages 2..NUM_STAGE-1: product and control carry ----
        always_ff @(posedge clk) begin
          if (reset) begin
            for (int s = 2; s <= LAST; s++) begin
              vld_pn[s]  <= 1'b0;
              en_pn[s]   <= 1'b0;
              clr_pn[s]  <= 1'b0;
              word_pn[s] <= '0;
            end
          end else if (bus.ce) begin
            vld_pn[2]  <= vld_p1;
            en_pn[2]   <= en_p1;
            clr_pn[2]  <= clr_p1;
            word_pn[2] <= word_p1;
            for (int s = 3; s <= LAST; s++) begin
              vld_pn[s]  <= vld_pn[s-1];
              en_pn[s]   <= en_pn[s-1];
              clr_pn[s]  <= clr_pn[s-1];
              word_pn[s] <= word_pn[s-1];
            end
          end
        end

        assign fin_vld  = vld_pn[LAST];
        assign fin_en   = en_pn[LAST];
        assign fin_clr  = clr_pn[LAST];
        assign fin_word = word_pn[LAST];
      end
    end
  endgenerate

  logic                 out_vld;
  logic signed [DW-1:0] acc;
  logic signed [DW-1:0] fin_prod;

  assign fin_prod = fin_word[DW-1:0];

`ifdef CONV_MUL_MAC_SAT_EN
  logic          fin_psat;
  logic [DW:0]   sum_word;
  logic          sat_r;

  assign fin_psat = fin_word[DW];
  assign sum_word = add_acc(acc, fin_prod);
`endif

  // ---- final stage: accumulator update ----
  // Bubbles clear out_valid but leave acc (and sat_flag) untouched so a
  // running sum survives gaps in the tap stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld <= 1'b0;
      acc     <= '0;
`ifdef CONV_MUL_MAC_SAT_EN
      sat_r   <= 1'b0;
`endif
    end else if (bus.ce) begin
      out_vld <= fin_vld;
      if (fin_vld) begin
        if (fin_en && !fin_clr) begin
`ifdef CONV_MUL_MAC_SAT_EN
          acc   <= sum_word[DW-1:0];
          sat_r <= sum_word[DW] | fin_psat;
`else
          acc   <= add_acc(acc, fin_prod);
`endif
        end else begin
          acc   <= fin_prod;
`ifdef CONV_MUL_MAC_SAT_EN
          sat_r <= fin_psat;
`endif
        end
      end
    end
  end

  assign bus.out_valid = out_vld;
  assign bus.dout      = acc;
`ifdef CONV_MUL_MAC_SAT_EN
  assign bus.sat_flag  = sat_r;
`endif

endmodule

// File: tb/tb_conv_mul_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_conv_mul_mac_pipe
// Directed bench for conv_mul_mac_pipe. Three NUM_STAGE = 3 instances share
// the same stimulus: dout_WIDTH 32 (main, tracked by a small latency model),
// 16 (truncation/saturation of the product) and 24 (accumulator overflow).
// Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_conv_mul_mac_pipe;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  conv_mul_mac_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(32)) if32 ();
  conv_mul_mac_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(16)) if16 ();
  conv_mul_mac_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(24)) if24 ();

  conv_mul_mac_pipe #(.ID(32'd1), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(32))
    dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  conv_mul_mac_pipe #(.ID(32'd2), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(16))
    dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  conv_mul_mac_pipe #(.ID(32'd3), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(24))
    dut24 (.clk(clk), .reset(reset), .bus(if24.slave));

  int total = 0;
  int bad   = 0;

  // Latency model for the 32-bit instance: two in-flight slots then the sum.
  logic   m_v   [2] = '{1'b0, 1'b0};
  logic   m_en  [2] = '{1'b0, 1'b0};
  logic   m_clr [2] = '{1'b0, 1'b0};
  longint m_p   [2] = '{0, 0};
  logic   m_ov      = 1'b0;
  longint m_acc     = 0;

  task automatic ckv(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ckb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic iv, input logic en, input logic clr,
                       input int a, input int b);
    if32.ce = c; if32.in_valid = iv; if32.acc_en = en; if32.acc_clr = clr;
    if32.din0 = a[15:0]; if32.din1 = b[7:0];
    if16.ce = c; if16.in_valid = iv; if16.acc_en = en; if16.acc_clr = clr;
    if16.din0 = a[15:0]; if16.din1 = b[7:0];
    if24.ce = c; if24.in_valid = iv; if24.acc_en = en; if24.acc_clr = clr;
    if24.din0 = a[15:0]; if24.din1 = b[7:0];
  endtask

  // Advance the model with the currently driven inputs, then clock the DUTs.
  task automatic tick();
    if (reset) begin
      m_v[0] = 1'b0; m_v[1] = 1'b0; m_ov = 1'b0; m_acc = 0;
    end else if (if32.ce) begin
      if (m_v[1]) begin
        m_ov = 1'b1;
        if (m_en[1] && !m_clr[1]) m_acc = m_acc + m_p[1];
        else                      m_acc = m_p[1];
      end else begin
        m_ov = 1'b0;
      end
      m_v[1] = m_v[0]; m_en[1] = m_en[0]; m_clr[1] = m_clr[0]; m_p[1] = m_p[0];
      m_v[0] = if32.in_valid; m_en[0] = if32.acc_en; m_clr[0] = if32.acc_clr;
      m_p[0] = longint'(if32.din0) * longint'(if32.din1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic c, input logic iv, input logic en, input logic clr,
                      input int a, input int b);
    drive(c, iv, en, clr, a, b);
    tick();
    ckb("model_out_valid", if32.out_valid, m_ov);
    ckv("model_dout", longint'(if32.dout), m_acc);
  endtask

  initial begin
    // Reset for two edges
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    tick();
    ckb("rst_ov32", if32.out_valid, 1'b0);
    ckv("rst_dout32", longint'(if32.dout), 0);
    ckv("rst_dout16", longint'(if16.dout), 0);
    ckv("rst_dout24", longint'(if24.dout), 0);
    reset = 1'b0;

    // Latency: -300 * 7 appears after the third enabled edge
    step(1'b1, 1'b1, 1'b0, 1'b0, -300, 7);
    ckb("lat_e1_ov", if32.out_valid, 1'b0);
    ckv("lat_e1_dout", longint'(if32.dout), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckb("lat_e2_ov", if32.out_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckb("lat_e3_ov", if32.out_valid, 1'b1);
    ckv("lat_e3_dout", longint'(if32.dout), -2100);
    ckv("lat_e3_dout16", longint'(if16.dout), -2100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckb("lat_bubble_ov", if32.out_valid, 1'b0);
    ckv("lat_bubble_hold", longint'(if32.dout), -2100);

    // 3x3 dot product: sum(1..9) * 2 = 90
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, 1'b1, (i == 1), i, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckb("dot_ov", if32.out_valid, 1'b1);
    ckv("dot_dout", longint'(if32.dout), 90);
    ckv("dot_dout24", longint'(if24.dout), 90);
`ifdef CONV_MUL_MAC_SAT_EN
    ckb("dot_sat32", if32.sat_flag, 1'b0);
`endif
    // New window: 5 * -1
    step(1'b1, 1'b1, 1'b1, 1'b1, 5, -1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckv("win2_dout", longint'(if32.dout), -5);

    // Dot product with a 4-cycle stall and input bubbles
    step(1'b1, 1'b1, 1'b1, 1'b1, 1, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 6, 2);
    ckb("pre_stall_ov", if32.out_valid, 1'b1);
    ckv("pre_stall_dout", longint'(if32.dout), 20);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 99, 2);
      ckb("stall_ov", if32.out_valid, 1'b1);
      ckv("stall_dout", longint'(if32.dout), 20);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckv("post_stall_dout", longint'(if32.dout), 30);
    step(1'b1, 1'b1, 1'b1, 1'b0, 7, 2);
    ckv("post_stall_dout2", longint'(if32.dout), 42);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8, 2);
    ckb("bubble_out_ov", if32.out_valid, 1'b0);
    ckv("bubble_out_hold", longint'(if32.dout), 42);
    step(1'b1, 1'b1, 1'b1, 1'b0, 9, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckb("stall_final_ov", if32.out_valid, 1'b1);
    ckv("stall_final_dout", longint'(if32.dout), 90);

    // Extremes: -32768 * -128 = 4194304 (low 16 bits are 0)
    step(1'b1, 1'b1, 1'b0, 1'b0, -32768, -128);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckv("ext_dout32", longint'(if32.dout), 4194304);
    ckv("ext_dout24", longint'(if24.dout), 4194304);
`ifdef CONV_MUL_MAC_SAT_EN
    ckv("ext_dout16_sat", longint'(if16.dout), 32767);
    ckb("ext_sat16", if16.sat_flag, 1'b1);
    ckb("ext_sat24", if24.sat_flag, 1'b0);
`else
    ckv("ext_dout16", longint'(if16.dout), 0);
`endif

    // Overflow: 3 * (32767 * 127) = 12484227, past the 24-bit range
    step(1'b1, 1'b1, 1'b1, 1'b1, 32767, 127);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32767, 127);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32767, 127);
    ckv("ovf_partial24", longint'(if24.dout), 4161409);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckv("ovf_partial24b", longint'(if24.dout), 8322818);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckv("ovf_dout32", longint'(if32.dout), 12484227);
`ifdef CONV_MUL_MAC_SAT_EN
    ckv("ovf_dout24_sat", longint'(if24.dout), 8388607);
    ckb("ovf_sat24", if24.sat_flag, 1'b1);
`else
    ckv("ovf_dout24_wrap", longint'(if24.dout), -4292989);
`endif

    // Reset (during a stall) with two taps in flight
    step(1'b1, 1'b1, 1'b1, 1'b1, 3, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4, 3);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    ckb("midrst_ov", if32.out_valid, 1'b0);
    ckv("midrst_dout", longint'(if32.dout), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      ckb("midrst_flush_ov", if32.out_valid, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 3, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckv("after_rst_first", longint'(if32.dout), 9);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ckv("after_rst_dout", longint'(if32.dout), 21);
    ckv("after_rst_dout16", longint'(if16.dout), 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
